// File: rtl/layer_out_serializer.sv
// Layer output serializer: gathers one word per neuron as each neuron reports,
// then streams the complete frame one word per cycle, neuron 0 first, onto the
// next layer's shared input bus. A downstream hold stalls the stream. Any
// duplicate or out-of-phase valid pulse sets a sticky overflow flag.
module layer_out_serializer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16,
  parameter int cntWidth   = $clog2(numNeurons)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [numNeurons*dataWidth-1:0]  x_in,
  input  logic [numNeurons-1:0]            x_valid,
  input  logic                             hold,
  output logic [dataWidth-1:0]             data_out,
  output logic                             data_out_valid,
  output logic                             busy,
  output logic                             overflow,
  output logic                             frame_done
);

  typedef enum logic {COLLECT = 1'b0, SHIFT = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [numNeurons-1:0] mask_reg, mask_next, mask_upd, capture;
  logic [cntWidth-1:0]   counter_reg, counter_next;
  logic                  emit, last_word, violation;

  // Word buffer is deliberately left out of reset; the mask says what is valid.
  logic [dataWidth-1:0]  buffer [numNeurons];

  // Next-state logic: capture decode, mask update, counter advance.
  always_comb begin
    capture      = '0;
    violation    = 1'b0;
    state_next   = state_reg;
    mask_next    = mask_reg;
    counter_next = counter_reg;
    emit         = (state_reg == SHIFT) && !hold;
    last_word    = emit && (counter_reg == cntWidth'(numNeurons - 1));
    mask_upd     = mask_reg;
    case (state_reg)
      COLLECT: begin
        // Only first arrivals are captured; repeats are flagged instead.
        capture   = x_valid & ~mask_reg;
        violation = |(x_valid & mask_reg);
        mask_upd  = mask_reg | capture;
        // Mask is judged after this edge's captures, so the final words can
        // arrive on the very edge that launches the shift.
        if (&mask_upd) begin
          state_next   = SHIFT;
          mask_next    = '0;
          counter_next = '0;
        end else begin
          mask_next = mask_upd;
        end
      end
      SHIFT: begin
        // Nothing may report while the frame is draining; it is dropped.
        violation = |x_valid;
        if (emit) begin
          counter_next = counter_reg + cntWidth'(1);
          if (last_word) begin
            state_next = COLLECT;
          end
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // State, capture mask and shift counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= COLLECT;
      mask_reg    <= '0;
      counter_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      counter_reg <= counter_next;
    end
  end

  // Capture each newly reporting neuron's word into its buffer slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < numNeurons; i++) begin
      if (capture[i]) begin
        buffer[i] <= x_in[i*dataWidth +: dataWidth];
      end
    end
  end

  // Registered outputs: serial word, strobes, busy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      data_out_valid <= emit;
      frame_done     <= last_word;
      busy           <= (state_next == SHIFT);
      if (emit) begin
        data_out <= buffer[counter_reg];
      end
      if (violation) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer with four 16-bit neurons.
// A table of per-cycle vectors covers the streaming cases; hand-written
// sequences cover async reset mid-frame and pulses arriving during a shift.
module tb_layer_out_serializer;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] x_in;
  logic [N-1:0]   x_valid;
  logic           hold;
  logic [W-1:0]   data_out;
  logic           data_out_valid;
  logic           busy;
  logic           overflow;
  logic           frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0]   xv;
    logic [N*W-1:0] xin;
    logic           hold;
    logic [W-1:0]   dout;
    logic           chk_dout;
    logic           dv;
    logic           fd;
    logic           busy;
    logic           ovf;
  } vec_t;

  vec_t vecs[$];

  layer_out_serializer #(.numNeurons(N), .dataWidth(W)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .hold(hold),
    .data_out(data_out), .data_out_valid(data_out_valid), .busy(busy),
    .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [N-1:0] xv, input logic [N*W-1:0] xin,
                              input logic h, input logic [W-1:0] dout, input logic cd,
                              input logic dv, input logic fd, input logic bz, input logic ovf);
    vec_t v;
    v.xv = xv; v.xin = xin; v.hold = h; v.dout = dout; v.chk_dout = cd;
    v.dv = dv; v.fd = fd; v.busy = bz; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] dout, input logic cd,
                         input logic dv, input logic fd, input logic bz, input logic ovf);
    $display("%s: dout=%h dv=%b fd=%b busy=%b ovf=%b", tag, data_out, data_out_valid,
             frame_done, busy, overflow);
    if (cd) chk({tag, ".data_out"}, 32'(data_out), 32'(dout));
    chk({tag, ".data_out_valid"}, 32'(data_out_valid), 32'(dv));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic tick(input logic [N-1:0] xv, input logic [N*W-1:0] xin, input logic h);
    x_valid = xv;
    x_in    = xin;
    hold    = h;
    @(posedge clk);
    #1;
  endtask

  localparam logic [N*W-1:0] IDLE = {4{16'hEEEE}};

  initial begin
    // Test 1: all neurons at once.
    vecs.push_back(mk(4'hF, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 0, 16'h0000, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h0001, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h0002, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h0003, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h0004, 1, 1, 1, 0, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h0004, 1, 0, 0, 0, 0));
    // Test 2: staggered arrivals 2, 0, 3, 1 with gaps.
    vecs.push_back(mk(4'b0100, {16'hFFFF, 16'h2C2C, 16'hFFFF, 16'hFFFF}, 0, 16'h0004, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0000, IDLE, 0, 16'h0004, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0001, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h2A2A}, 0, 16'h0004, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1000, {16'h2D2D, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 0, 16'h0004, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0000, IDLE, 0, 16'h0004, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0010, {16'hFFFF, 16'hFFFF, 16'h2B2B, 16'hFFFF}, 0, 16'h0004, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h2A2A, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h2B2B, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h2C2C, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h2D2D, 1, 1, 1, 0, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h2D2D, 1, 0, 0, 0, 0));
    // Test 3: hold for three cycles after the second word.
    vecs.push_back(mk(4'hF, {16'h3004, 16'h3003, 16'h3002, 16'h3001}, 0, 16'h2D2D, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h3001, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h3002, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 1, 16'h3002, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 1, 16'h3002, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 1, 16'h3002, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h3003, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h3004, 1, 1, 1, 0, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h3004, 1, 0, 0, 0, 0));
    // Test 6: back-to-back frames, second arrives during the frame_done cycle.
    vecs.push_back(mk(4'hF, {16'h6004, 16'h6003, 16'h6002, 16'h6001}, 0, 16'h3004, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h6001, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h6002, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h6003, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h6004, 1, 1, 1, 0, 0));
    vecs.push_back(mk(4'hF, {16'h7004, 16'h7003, 16'h7002, 16'h7001}, 0, 16'h6004, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h7001, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h7002, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h7003, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h7004, 1, 1, 1, 0, 0));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h7004, 1, 0, 0, 0, 0));
    // Test 4a: neuron 1 reports twice; the first word wins, overflow sticks.
    vecs.push_back(mk(4'b0010, {16'hFFFF, 16'hFFFF, 16'h4A4A, 16'hFFFF}, 0, 16'h7004, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0010, {16'hFFFF, 16'hFFFF, 16'h4B4B, 16'hFFFF}, 0, 16'h7004, 1, 0, 0, 0, 1));
    vecs.push_back(mk(4'b1101, {16'h4D4D, 16'h4C4C, 16'hFFFF, 16'h4040}, 0, 16'h7004, 1, 0, 0, 1, 1));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h4040, 1, 1, 0, 1, 1));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h4A4A, 1, 1, 0, 1, 1));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h4C4C, 1, 1, 0, 1, 1));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h4D4D, 1, 1, 1, 0, 1));
    vecs.push_back(mk(4'h0, IDLE, 0, 16'h4D4D, 1, 0, 0, 0, 1));

    // Power-on reset.
    rst = 1'b1; x_valid = '0; x_in = '0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 16'h0000, 1, 0, 0, 0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      tick(vecs[i].xv, vecs[i].xin, vecs[i].hold);
      chk_out($sformatf("vec%0d", i), vecs[i].dout, vecs[i].chk_dout, vecs[i].dv,
              vecs[i].fd, vecs[i].busy, vecs[i].ovf);
    end

    // Test 5: async reset mid-shift after the second word clears everything.
    tick(4'hF, {16'h5004, 16'h5003, 16'h5002, 16'h5001}, 0);
    chk_out("rst_mid.load", 16'h4D4D, 1, 0, 0, 1, 1);
    tick(4'h0, IDLE, 0);
    chk_out("rst_mid.w0", 16'h5001, 1, 1, 0, 1, 1);
    tick(4'h0, IDLE, 0);
    chk_out("rst_mid.w1", 16'h5002, 1, 1, 0, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk_out("rst_mid.async", 16'h0000, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(4'hF, {16'h5104, 16'h5103, 16'h5102, 16'h5101}, 0);
    chk_out("rst_new.load", 16'h0000, 1, 0, 0, 1, 0);
    for (int w = 0; w < N; w++) begin
      tick(4'h0, IDLE, 0);
      chk_out($sformatf("rst_new.w%0d", w), 16'h5101 + 16'(w), 1, 1, (w == N - 1), (w != N - 1), 0);
    end
    tick(4'h0, IDLE, 0);
    chk_out("rst_new.idle", 16'h5104, 1, 0, 0, 0, 0);

    // Test 4b: pulse during shift flags overflow and is not captured.
    tick(4'hF, {16'h8004, 16'h8003, 16'h8002, 16'h8001}, 0);
    chk_out("shp.load", 16'h5104, 1, 0, 0, 1, 0);
    tick(4'b0010, {4{16'h9999}}, 0);
    chk_out("shp.w0", 16'h8001, 1, 1, 0, 1, 1);
    tick(4'h0, IDLE, 0);
    chk_out("shp.w1", 16'h8002, 1, 1, 0, 1, 1);
    tick(4'h0, IDLE, 0);
    chk_out("shp.w2", 16'h8003, 1, 1, 0, 1, 1);
    tick(4'h0, IDLE, 0);
    chk_out("shp.w3", 16'h8004, 1, 1, 1, 0, 1);
    // Neuron 1 must still be missing: three reports alone do not start a shift.
    tick(4'b1101, {16'h9004, 16'h9003, 16'hFFFF, 16'h9001}, 0);
    chk_out("shp.partial", 16'h8004, 1, 0, 0, 0, 1);
    tick(4'b0010, {16'hFFFF, 16'hFFFF, 16'h9002, 16'hFFFF}, 0);
    chk_out("shp.complete", 16'h8004, 1, 0, 0, 1, 1);
    for (int w = 0; w < N; w++) begin
      tick(4'h0, IDLE, 0);
      chk_out($sformatf("shp.next.w%0d", w), 16'h9001 + 16'(w), 1, 1, (w == N - 1), (w != N - 1), 1);
    end
    tick(4'h0, IDLE, 0);
    chk_out("shp.idle", 16'h9004, 1, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
